seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed-pattern "010" Mealy snail FSM.
- Pattern, length, overlap mode and output style (Mealy/Moore) are set at elaboration.
- Adds an input-enable qualifier and an optional saturating match counter.
- Sits on a 1-bit serial data stream in the lab FSM set and drives a match strobe to downstream logic.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- PATTERN, 3'b010, pattern value, PAT_W bits wide; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = a match consumes its bits.
- MOORE, 0, 0 = Mealy combinational Q; 1 = Moore registered Q.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  input  1  rising-edge clock.
- _rst  input  1  asynchronous active-low reset.
- D  input  1  serial data bit, sampled on rising clk when en=1.
- en  input  1  bit-valid qualifier.
- Q  output  1  match strobe.
- state_idx  output  5  current state index (number of pattern bits matched), for debug.
- match_cnt  output  CNT_W  saturating match count; exists only with SEQDET_MATCH_CNT_EN.

Behaviour:
- Reset: _rst=0 forces state=S0 asynchronously. Q=0, state_idx=0, match_cnt=0. Reset applied mid-sequence discards any partial match.
- States Sk, with k = pattern bits currently matched:
  - Mealy: S0..S(PAT_W-1).
  - Moore: S0..S(PAT_W).
- Transitions occur on rising clk only when en=1. With en=0, state, Q (Moore) and match_cnt hold.
- From Sk with k<PAT_W:
  - If D equals PATTERN[PAT_W-1-k], go to S(k+1).
  - Otherwise go to Sj, where j = length of the longest pattern prefix that is a suffix of (the k matched bits followed by D). This is the KMP fallback; it is not a blind return to S0.
  - The transition table is computed at elaboration from PATTERN; no run-time division or search logic.
- Mealy (MOORE=0):
  - Q = en & (state==S(PAT_W-1)) & (D==PATTERN[0]), combinational, visible in the same cycle as the final bit.
  - On that edge the next state is:
    - OVERLAP=1: S(f), where f = longest proper prefix of the pattern that is also a suffix of it.
    - OVERLAP=0: S0.
- Moore (MOORE=1):
  - Q=1 exactly while state==S(PAT_W), i.e. from the edge that samples the final bit until the next enabled edge. Latency is one cycle later than Mealy.
  - From S(PAT_W):
    - OVERLAP=1: behave as from S(f).
    - OVERLAP=0: behave as from S0.
  - If en=0 while in S(PAT_W), Q stays high (state holds).
- Every state transitions on both D values; there are no dead states.
- X or Z on D while en=1 is a bench error and is not handled.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined:
  - match_cnt port exists.
  - It increments by 1 on each enabled edge that completes a match (the edge on which Mealy Q=1, or the edge entering S(PAT_W) in Moore).
  - It saturates at 2^CNT_W-1 and never wraps.
  - Reset clears it to 0.
- Undefined: the match_cnt port and its register are absent; all other behaviour is identical.

Test Plan:
- Default params (010, Mealy, overlap), en=1, D stream 0,1,0,1,0 → Q=1 combinationally during the 3rd and 5th bit cycles only; match_cnt=2 after the 5th edge.
- OVERLAP=0, same stream 0,1,0,1,0 → Q=1 only during the 3rd bit; match_cnt=1; state_idx=1 after the 5th edge.
- MOORE=1, stream 0,1,0,0 → Q rises just after the 3rd edge, falls after the 4th edge; state_idx=3 then 1.
- PAT_W=4, PATTERN=4'b1101, stream 1,1,0,1,1,0,1:
  - OVERLAP=1 → 2 matches (bits 4 and 7).
  - OVERLAP=0 → 1 match (bit 4).
  - Stream 1,1,1,0,1 → match at bit 5, exercising the fallback from S2 on a second '1'.
- Stream 0,1, then en=0 for 3 cycles with D toggling, then en=1 with D=0 → no Q while en=0; Q=1 on the resumed bit. Then pull _rst low asynchronously mid-stream after 0,1 → state_idx=0 and match_cnt=0 immediately; a following 0 does not match.
- CNT_W=2 with SEQDET_MATCH_CNT_EN, 5 consecutive 010 matches → match_cnt goes 1,2,3,3,3.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial bit-pattern detector (Mealy or Moore).
//
// Tracks how many leading pattern bits have been matched.
// On a mismatch it falls back to the longest pattern prefix that is still a suffix
// of the received bits. That fallback table is built at elaboration from PATTERN.
//
// Parameters:
//   PAT_W   - pattern length, 2..16
//   PATTERN - pattern value; PATTERN[PAT_W-1] is the first bit received
//   OVERLAP - 1: matches may overlap; 0: a match consumes its bits
//   MOORE   - 0: combinational Mealy strobe; 1: registered Moore strobe
//   CNT_W   - width of match_cnt
//
// Ports:
//   clk       - rising-edge clock
//   _rst      - asynchronous active-low reset
//   D         - serial data bit, sampled when en=1
//   en        - bit-valid qualifier
//   Q         - match strobe
//   state_idx - number of pattern bits currently matched (debug)
//   match_cnt - saturating match count (only with SEQDET_MATCH_CNT_EN defined)
//
// Optional feature macro: SEQDET_MATCH_CNT_EN
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b010,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b0,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             D,
    input  logic             en,
    output logic             Q,
    output logic [4:0]       state_idx
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_param_check
        $error("seq_detector_param: illegal PAT_W or CNT_W");
    end

    // Highest reachable state index: Moore adds the "full match" state S(PAT_W).
    localparam int unsigned LAST = MOORE ? PAT_W : PAT_W - 1;

    localparam logic [4:0] S0     = 5'd0;
    localparam logic [4:0] S_LAST = 5'(PAT_W - 1);
    localparam logic [4:0] S_FULL = 5'(PAT_W);

    // Pattern bit in arrival order (index 0 arrives first).
    function automatic logic pbit(int unsigned i);
        return PATTERN[PAT_W-1-i];
    endfunction

    // Longest j <= maxj such that the first j pattern bits equal the last j bits
    // of the sequence (first k pattern bits, then d).
    function automatic int unsigned suffix_match(int unsigned k, logic d, int unsigned maxj);
        int unsigned len;
        int unsigned best;
        int unsigned pos;
        logic        ok;
        logic        sb;
        len  = k + 1;
        best = 0;
        for (int unsigned j = 1; j <= maxj && j <= len; j++) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < j; i++) begin
                pos = len - j + i;
                sb  = (pos < k) ? pbit(pos) : d;
                if (sb != pbit(i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // Longest proper border of the whole pattern.
    localparam int unsigned F = suffix_match(PAT_W - 1, PATTERN[0], PAT_W - 1);

    function automatic int unsigned next_state(int unsigned k, logic d);
        int unsigned base;
        if (k == PAT_W) begin
            // Moore full-match state re-enters the search from the restart point.
            base = OVERLAP ? F : 0;
            return suffix_match(base, d, PAT_W);
        end
        if (!MOORE && k == PAT_W - 1 && d == pbit(PAT_W - 1)) begin
            return OVERLAP ? F : 0;
        end
        return suffix_match(k, d, PAT_W);
    endfunction

    logic [4:0] state_q;
    logic [4:0] state_d;
    logic [4:0] nxt;

    // Constant transition table folded into a one-hot-selected OR chain.
    // Unreachable encodings select nothing and recover to S0.
    logic [4:0] chain [0:LAST+1];
    assign chain[0] = S0;

    for (genvar g = 0; g <= LAST; g++) begin : g_tbl
        localparam int unsigned K  = g;
        localparam logic [4:0]  KS = 5'(K);
        localparam logic [4:0]  N0 = 5'(next_state(K, 1'b0));
        localparam logic [4:0]  N1 = 5'(next_state(K, 1'b1));
        assign chain[g+1] = chain[g] | ((state_q == KS) ? (D ? N1 : N0) : 5'd0);
    end

    assign nxt = chain[LAST+1];

    always_comb begin
        state_d = state_q;
        if (en) state_d = nxt;
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_idx = state_q;
    assign Q = MOORE ? (state_q == S_FULL)
                     : (en & (state_q == S_LAST) & (D == PATTERN[0]));

`ifdef SEQDET_MATCH_CNT_EN
    logic             hit;
    logic [CNT_W-1:0] cnt_q;

    // Mealy counts the strobe itself; Moore counts entry into the full state.
    assign hit = MOORE ? (en & (nxt == S_FULL)) : Q;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule
